// File: rtl/spectrum_pkg.sv
// Shared constants and write-side state type for the sample frame buffers.
package spectrum_pkg;

  localparam int unsigned DATA_BITS = 16;
  localparam int unsigned ADDR_BITS = 10;
  localparam int unsigned FRAME_LEN = 2 ** ADDR_BITS;

  typedef enum logic {
    FILL,
    FULL
  } wr_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
module sat_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] cnt_d, cnt_q;

  // Next count: clear wins, otherwise increment and stick at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {Width{1'b1}})) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/frame_writer.sv
// Ping-pong frame write controller: packs samples into frames and swaps buffers
// only once the reader has released the other buffer.
module frame_writer
  import spectrum_pkg::*;
#(
  parameter int unsigned DROP_BITS = 16
) (
  input  logic                 clk1,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] sample_i,
  input  logic                 sample_valid_i,
  input  logic                 rd_done_i,
  output logic                 buff_sel_o,
  output logic [ADDR_BITS-1:0] buff_waddr_o,
  output logic [DATA_BITS-1:0] buff_wdata_o,
  output logic                 frame_rdy_o,
  output logic                 frame_tgl_o,
  output logic [DROP_BITS-1:0] drop_cnt_o
);

  localparam logic [ADDR_BITS:0] LastAddr = (ADDR_BITS + 1)'(FRAME_LEN - 1);

  wr_state_t            state_d, state_q;
  logic [ADDR_BITS:0]   next_addr_d, next_addr_q;
  logic                 rd_free_d, rd_free_q;
  logic                 sel_d, sel_q;
  logic                 tgl_d, tgl_q;
  logic                 rdy_d, rdy_q;
  logic [ADDR_BITS-1:0] waddr_d, waddr_q;
  logic [DATA_BITS-1:0] wdata_d, wdata_q;
  logic                 swap_ok;
  logic                 drop_inc;

  // Next-state: accept samples while filling, swap or drop while the frame is full.
  always_comb begin
    state_d     = state_q;
    next_addr_d = next_addr_q;
    rd_free_d   = rd_free_q;
    sel_d       = sel_q;
    tgl_d       = tgl_q;
    rdy_d       = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    drop_inc    = 1'b0;
    swap_ok     = rd_free_q | rd_done_i;

    if (rd_done_i) begin
      rd_free_d = 1'b1;
    end

    unique case (state_q)
      FILL: begin
        if (sample_valid_i) begin
          waddr_d     = next_addr_q[ADDR_BITS-1:0];
          wdata_d     = sample_i;
          next_addr_d = next_addr_q + (ADDR_BITS + 1)'(1);
          if (next_addr_q == LastAddr) begin
            state_d = FULL;
          end
        end
      end
      FULL: begin
        if (swap_ok) begin
          sel_d     = ~sel_q;
          tgl_d     = ~tgl_q;
          rdy_d     = 1'b1;
          rd_free_d = 1'b0;  // swap consumes any coincident release
          waddr_d   = '0;
          state_d   = FILL;
          if (sample_valid_i) begin
            wdata_d     = sample_i;
            next_addr_d = (ADDR_BITS + 1)'(1);
          end else begin
            next_addr_d = '0;
          end
        end else if (sample_valid_i) begin
          drop_inc = 1'b1;
        end
      end
    endcase
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q     <= FILL;
      next_addr_q <= '0;
      rd_free_q   <= 1'b1;
      sel_q       <= 1'b0;
      tgl_q       <= 1'b0;
      rdy_q       <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      next_addr_q <= next_addr_d;
      rd_free_q   <= rd_free_d;
      sel_q       <= sel_d;
      tgl_q       <= tgl_d;
      rdy_q       <= rdy_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
    end
  end

  sat_counter #(
    .Width(DROP_BITS)
  ) u_drop_cnt (
    .clk_i (clk1),
    .clr_i (rst),
    .inc_i (drop_inc),
    .cnt_o (drop_cnt_o)
  );

  assign buff_sel_o   = sel_q;
  assign buff_waddr_o = waddr_q;
  assign buff_wdata_o = wdata_q;
  assign frame_rdy_o  = rdy_q;
  assign frame_tgl_o  = tgl_q;

endmodule

// File: tb/tb_frame_writer.sv
// Bench for frame_writer: directed scenarios plus a randomized full-rate stream,
// all checked every cycle against a frame-level behavioural model.
module tb_frame_writer;
  import spectrum_pkg::*;

  localparam int unsigned DROP_BITS = 16;
  localparam int DropMax = (2 ** DROP_BITS) - 1;

  logic                 clk1 = 1'b0;
  logic                 rst = 1'b1;
  logic [DATA_BITS-1:0] sample_i = '0;
  logic                 sample_valid_i = 1'b0;
  logic                 rd_done_i = 1'b0;
  logic                 buff_sel_o;
  logic [ADDR_BITS-1:0] buff_waddr_o;
  logic [DATA_BITS-1:0] buff_wdata_o;
  logic                 frame_rdy_o;
  logic                 frame_tgl_o;
  logic [DROP_BITS-1:0] drop_cnt_o;

  frame_writer #(
    .DROP_BITS(DROP_BITS)
  ) dut (
    .clk1           (clk1),
    .rst            (rst),
    .sample_i       (sample_i),
    .sample_valid_i (sample_valid_i),
    .rd_done_i      (rd_done_i),
    .buff_sel_o     (buff_sel_o),
    .buff_waddr_o   (buff_waddr_o),
    .buff_wdata_o   (buff_wdata_o),
    .frame_rdy_o    (frame_rdy_o),
    .frame_tgl_o    (frame_tgl_o),
    .drop_cnt_o     (drop_cnt_o)
  );

  always #5 clk1 = ~clk1;

  int vectors = 0;
  int miscompares = 0;
  int rdy_pulses = 0;
  bit started = 1'b0;

  // Frame-level model: how many samples the current frame holds, whether the
  // reader has released the other buffer, and what the outputs must show.
  int m_cnt = 0;
  bit m_free = 1'b1;
  bit m_sel = 1'b0;
  bit m_tgl = 1'b0;
  bit m_rdy = 1'b0;
  int m_waddr = 0;
  int m_wdata = 0;
  int m_drop = 0;

  always @(posedge clk1) begin
    started = 1'b1;
    if (rst) begin
      m_cnt = 0; m_free = 1'b1; m_sel = 1'b0; m_tgl = 1'b0; m_rdy = 1'b0;
      m_waddr = 0; m_wdata = 0; m_drop = 0;
    end else begin
      m_rdy = 1'b0;
      if (m_cnt < FRAME_LEN) begin
        if (rd_done_i) m_free = 1'b1;
        if (sample_valid_i) begin
          m_waddr = m_cnt;
          m_wdata = int'(sample_i);
          m_cnt++;
        end
      end else if (m_free || rd_done_i) begin
        m_sel = ~m_sel; m_tgl = ~m_tgl; m_rdy = 1'b1; m_free = 1'b0; m_waddr = 0;
        if (sample_valid_i) begin
          m_wdata = int'(sample_i);
          m_cnt = 1;
        end else begin
          m_cnt = 0;
        end
      end else if (sample_valid_i && m_drop < DropMax) begin
        m_drop++;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk1) begin
    if (started) begin
      vectors++;
      if (buff_sel_o !== m_sel || frame_tgl_o !== m_tgl || frame_rdy_o !== m_rdy ||
          buff_waddr_o !== ADDR_BITS'(m_waddr) || buff_wdata_o !== DATA_BITS'(m_wdata) ||
          drop_cnt_o !== DROP_BITS'(m_drop)) begin
        miscompares++;
        $display("FAIL model t=%0t: got sel=%b tgl=%b rdy=%b addr=%0d data=%h drop=%0d, expected sel=%b tgl=%b rdy=%b addr=%0d data=%h drop=%0d",
                 $time, buff_sel_o, frame_tgl_o, frame_rdy_o, buff_waddr_o, buff_wdata_o,
                 drop_cnt_o, m_sel, m_tgl, m_rdy, m_waddr[ADDR_BITS-1:0],
                 m_wdata[DATA_BITS-1:0], m_drop);
      end
      if (frame_rdy_o === 1'b1) rdy_pulses++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk1);
    #1;
  endtask

  task automatic strobe(input logic [DATA_BITS-1:0] data, input int gap);
    sample_valid_i = 1'b1;
    sample_i = data;
    cycle();
    sample_valid_i = 1'b0;
    repeat (gap) cycle();
  endtask

  int stall;

  initial begin
    // Reset held for 3 cycles with random inputs.
    rst = 1'b1;
    repeat (3) begin
      sample_i = DATA_BITS'($urandom);
      sample_valid_i = 1'($urandom);
      rd_done_i = 1'($urandom);
      cycle();
    end
    check("rst_sel", 32'(buff_sel_o), 0);
    check("rst_waddr", 32'(buff_waddr_o), 0);
    check("rst_wdata", 32'(buff_wdata_o), 0);
    check("rst_rdy", 32'(frame_rdy_o), 0);
    check("rst_tgl", 32'(frame_tgl_o), 0);
    check("rst_drop", 32'(drop_cnt_o), 0);
    rst = 1'b0;
    sample_valid_i = 1'b0;
    rd_done_i = 1'b0;
    cycle();
    check("rel_sel", 32'(buff_sel_o), 0);
    check("rel_waddr", 32'(buff_waddr_o), 0);

    // First frame, one strobe every 64 cycles, data = index.
    for (int i = 0; i < FRAME_LEN; i++) strobe(DATA_BITS'(i), (i == FRAME_LEN - 1) ? 0 : 63);
    check("f1_last_addr", 32'(buff_waddr_o), 1023);
    check("f1_last_data", 32'(buff_wdata_o), 1023);
    cycle();
    check("f1_sel", 32'(buff_sel_o), 1);
    check("f1_rdy", 32'(frame_rdy_o), 1);
    check("f1_tgl", 32'(frame_tgl_o), 1);
    check("f1_waddr", 32'(buff_waddr_o), 0);
    cycle();
    check("f1_rdy_end", 32'(frame_rdy_o), 0);

    // Second frame with the reader still busy: 5 extra samples are dropped.
    for (int i = 0; i < FRAME_LEN; i++) strobe(DATA_BITS'($urandom), $urandom_range(0, 2));
    for (int i = 0; i < 5; i++) strobe(DATA_BITS'($urandom), 1);
    check("stall_sel", 32'(buff_sel_o), 1);
    check("stall_drop", 32'(drop_cnt_o), 5);
    check("stall_model_drop", 32'(m_drop), 5);
    rd_done_i = 1'b1;
    cycle();
    rd_done_i = 1'b0;
    check("rel_swap_sel", 32'(buff_sel_o), 0);
    check("rel_swap_tgl", 32'(frame_tgl_o), 0);
    check("rel_swap_rdy", 32'(frame_rdy_o), 1);

    // Release and sample arrive in the same FULL cycle.
    for (int i = 0; i < FRAME_LEN; i++) strobe(DATA_BITS'($urandom), $urandom_range(0, 1));
    repeat (2) cycle();
    rd_done_i = 1'b1;
    sample_valid_i = 1'b1;
    sample_i = 16'h7FFF;
    cycle();
    rd_done_i = 1'b0;
    sample_valid_i = 1'b0;
    check("co_sel", 32'(buff_sel_o), 1);
    check("co_waddr", 32'(buff_waddr_o), 0);
    check("co_wdata", 32'(buff_wdata_o), 32'h7FFF);
    check("co_drop", 32'(drop_cnt_o), 5);
    strobe(16'h1234, 0);
    check("co_next_addr", 32'(buff_waddr_o), 1);
    check("co_next_data", 32'(buff_wdata_o), 32'h1234);

    // Reset after sample 500 of a frame in buffer2.
    for (int i = 0; i < 498; i++) strobe(DATA_BITS'($urandom), $urandom_range(0, 1));
    check("mid_pre_addr", 32'(buff_waddr_o), 499);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("mid_sel", 32'(buff_sel_o), 0);
    check("mid_waddr", 32'(buff_waddr_o), 0);
    check("mid_tgl", 32'(frame_tgl_o), 0);
    check("mid_drop", 32'(drop_cnt_o), 0);
    rdy_pulses = 0;
    for (int i = 0; i < FRAME_LEN; i++) strobe(DATA_BITS'($urandom), 0);
    repeat (3) cycle();
    check("mid_swaps", 32'(rdy_pulses), 1);
    check("mid_sel_after", 32'(buff_sel_o), 1);

    // Full-rate stream; the reader releases 100 cycles into each stall.
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    rdy_pulses = 0;
    stall = 0;
    for (int c = 0; c < 3300; c++) begin
      sample_valid_i = 1'b1;
      sample_i = DATA_BITS'($urandom);
      rd_done_i = 1'b0;
      if (m_cnt == FRAME_LEN && !m_free) begin
        if (stall == 100) begin
          rd_done_i = 1'b1;
          stall = 0;
        end else begin
          stall++;
        end
      end
      cycle();
    end
    sample_valid_i = 1'b0;
    rd_done_i = 1'b0;
    repeat (3) cycle();
    // Frame 1 swaps freely; frames 2 and 3 each stall 100 full-rate cycles.
    check("fr_drop", 32'(drop_cnt_o), 200);
    check("fr_model_drop", 32'(m_drop), 200);
    check("fr_swaps", 32'(rdy_pulses), 3);
    check("fr_sel", 32'(buff_sel_o), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
